// File: rtl/mac_chain_pkg.sv
// Shared types and helpers for the chained keyed MAC generator.
// State encoding, default geometry and the rotate helper.
package mac_chain_pkg;

  localparam int DEF_DATA_W     = 256;
  localparam int DEF_MAX_CHUNKS = 16;
  localparam int DEF_ROT        = 8;

  // Widest vector rotl can handle; callers zero-extend into it.
  localparam int MAX_W = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABSORB = 2'd1,
    FINAL  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Left-rotate the low w bits of v by amt; bits above w must be zero.
  function automatic logic [MAX_W-1:0] rotl(
    input logic [MAX_W-1:0] v,
    input int unsigned      amt,
    input int unsigned      w
  );
    logic [MAX_W-1:0] mask;
    if (w >= MAX_W)
      mask = '1;
    else
      mask = (MAX_W'(1) << w) - MAX_W'(1);
    return ((v << amt) | (v >> (w - amt))) & mask;
  endfunction

endpackage

// File: rtl/mac_chain_gen.sv
// Streaming keyed MAC: chains chunks into an XOR/rotate accumulator,
// then folds in key and chunk count and hands the MAC off.
module mac_chain_gen
  import mac_chain_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_CHUNKS = DEF_MAX_CHUNKS,
  parameter int ROT        = DEF_ROT,
  localparam int CNT_W     = $clog2(MAX_CHUNKS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] key,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              mac_valid,
  input  logic              mac_ready,
  output logic [DATA_W-1:0] mac,
  output logic              err,
  output logic              busy
);

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] key_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc_rot;
  logic              hs;
  logic              at_max;

  assign hs      = in_valid & in_ready;
  assign at_max  = (cnt == CNT_W'(MAX_CHUNKS - 1));
  assign acc_rot = DATA_W'(rotl(MAX_W'(acc ^ in_data), ROT, DATA_W));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start) state_nxt = ABSORB;
      ABSORB: if (hs && (in_last || at_max)) state_nxt = FINAL;
      FINAL:  state_nxt = DONE;
      DONE:   if (mac_valid && mac_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Unregistered outputs decoded from state.
  always_comb begin
    in_ready = (state == ABSORB);
    busy     = (state != IDLE);
  end

  // Accumulator, counter and registered result path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      key_q     <= '0;
      cnt       <= '0;
      mac       <= '0;
      err       <= 1'b0;
      mac_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            key_q <= key;
            acc   <= key;
            cnt   <= '0;
            err   <= 1'b0;
          end
        end
        ABSORB: begin
          if (hs) begin
            acc <= acc_rot;
            cnt <= cnt + CNT_W'(1);
            if (!in_last && at_max)
              err <= 1'b1;
          end
        end
        FINAL: begin
          mac       <= acc ^ key_q ^ DATA_W'(cnt);
          mac_valid <= 1'b1;
        end
        DONE: begin
          if (mac_ready)
            mac_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_chain_gen.sv
// Self-checking bench for mac_chain_gen with a queue scoreboard.
// Uses MAX_CHUNKS=4 so the overflow path is reachable quickly.
module tb_mac_chain_gen;

  localparam int W  = 256;
  localparam int MC = 4;
  localparam int R  = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] key;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         mac_valid;
  logic         mac_ready;
  logic [W-1:0] mac;
  logic         err;
  logic         busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [W-1:0] m;
    logic         e;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] chunks[8];

  always #5 clk = ~clk;

  mac_chain_gen #(
    .DATA_W(W),
    .MAX_CHUNKS(MC),
    .ROT(R)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .key(key),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .mac_valid(mac_valid),
    .mac_ready(mac_ready),
    .mac(mac),
    .err(err),
    .busy(busy)
  );

  function automatic logic [W-1:0] m_rotl(input logic [W-1:0] v);
    return {v[W-R-1:0], v[W-1:W-R]};
  endfunction

  // Full message: start, n chunks, optional stall with a stray start.
  task automatic run_msg(input logic [W-1:0] k, input int n,
                         input logic last, input int stall,
                         input logic poke);
    logic [W-1:0] acc;
    logic [W-1:0] held;
    int           cnt;
    logic         e;
    exp_t         x;
    exp_t         got;
    start = 1'b1;
    key   = k;
    @(posedge clk);
    #1;
    start = 1'b0;
    key   = '1;
    acc   = k;
    cnt   = 0;
    e     = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = chunks[i];
      in_last  = last && (i == n - 1);
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL in_ready chunk %0d: got %b want 1", i, in_ready);
      end
      @(posedge clk);
      #1;
      acc = m_rotl(acc ^ chunks[i]);
      cnt++;
      if (!(last && i == n - 1) && cnt == MC) e = 1'b1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    sb.push_back({acc ^ k ^ W'(cnt), e});
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL in_ready after last: got %b want 0", in_ready);
    end
    total++;
    if (mac_valid !== 1'b0) begin
      bad++;
      $display("FAIL early valid: got %b want 0", mac_valid);
    end
    @(posedge clk);
    #1;
    total++;
    if (mac_valid !== 1'b1) begin
      bad++;
      $display("FAIL latency: mac_valid got %b want 1", mac_valid);
    end
    held = mac;
    for (int s = 0; s < stall; s++) begin
      if (poke && s == 1) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      total++;
      if (mac_valid !== 1'b1 || mac !== held ||
          in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL hold cyc %0d: valid=%b rdy=%b busy=%b want 1 0 1",
                 s, mac_valid, in_ready, busy);
      end
    end
    mac_ready = 1'b1;
    got = {mac, err};
    x   = sb.pop_front();
    total++;
    if (got !== x) begin
      bad++;
      $display("FAIL result: got mac=%h err=%b want mac=%h err=%b",
               got.m, got.e, x.m, x.e);
    end
    @(posedge clk);
    #1;
    mac_ready = 1'b0;
    total++;
    if (mac_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL handoff: valid=%b busy=%b want 0 0",
               mac_valid, busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0 || mac_valid !== 1'b0 || busy !== 1'b0 ||
        err !== 1'b0 || mac !== '0) begin
      bad++;
      $display("FAIL reset: rdy=%b valid=%b busy=%b err=%b want 0",
               in_ready, mac_valid, busy, err);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    chunks[0] = W'(1);
    run_msg('0, 1, 1'b1, 0, 1'b0);
    total++;
    if (mac !== W'(257) || err !== 1'b0) begin
      bad++;
      $display("FAIL single: got mac=%h err=%b want 101 0", mac, err);
    end
  endtask

  task automatic test_two;
    chunks[0] = W'(1);
    chunks[1] = W'(0);
    run_msg(W'(1), 2, 1'b1, 2, 1'b0);
    total++;
    if (mac !== W'(3)) begin
      bad++;
      $display("FAIL two: got mac=%h want 3", mac);
    end
  endtask

  task automatic test_backpressure;
    chunks[0] = W'(1);
    run_msg('0, 1, 1'b1, 5, 1'b1);
    total++;
    if (mac !== W'(257) || err !== 1'b0) begin
      bad++;
      $display("FAIL backpressure: got mac=%h err=%b want 101 0", mac, err);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < MC; i++) chunks[i] = '0;
    run_msg('0, MC, 1'b0, 0, 1'b0);
    total++;
    if (mac !== W'(4) || err !== 1'b1) begin
      bad++;
      $display("FAIL overflow: got mac=%h err=%b want 4 1", mac, err);
    end
  endtask

  task automatic test_max_last;
    for (int i = 0; i < MC; i++) chunks[i] = {8{$urandom()}};
    run_msg({8{$urandom()}}, MC, 1'b1, 1, 1'b0);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL max_last err: got %b want 0", err);
    end
  endtask

  task automatic test_back_to_back;
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 3; i++) chunks[i] = {8{$urandom()}};
      run_msg({8{$urandom()}}, 1 + m, 1'b1, m, 1'b0);
    end
  endtask

  task automatic test_mid_reset;
    chunks[0] = W'(7);
    start = 1'b1;
    key   = W'(9);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i + 3);
      @(posedge clk);
      #1;
    end
    in_data = W'(5);
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    total++;
    if (in_ready !== 1'b0 || mac_valid !== 1'b0 || busy !== 1'b0 ||
        err !== 1'b0 || mac !== '0) begin
      bad++;
      $display("FAIL mid_reset: rdy=%b valid=%b busy=%b err=%b want 0",
               in_ready, mac_valid, busy, err);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chunks[0] = W'(1);
    run_msg('0, 1, 1'b1, 0, 1'b0);
    total++;
    if (mac !== W'(257)) begin
      bad++;
      $display("FAIL after reset: got mac=%h want 101", mac);
    end
  endtask

  task automatic test_idle_gap;
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = W'(5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || mac_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle gap %0d: rdy=%b busy=%b valid=%b want 0",
                 i, in_ready, busy, mac_valid);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    chunks[0] = W'(1);
    run_msg('0, 1, 1'b1, 0, 1'b0);
    total++;
    if (mac !== W'(257)) begin
      bad++;
      $display("FAIL idle single: got mac=%h want 101", mac);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    key       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    mac_ready = 1'b0;
    test_reset();
    test_single();
    test_two();
    test_backpressure();
    test_overflow();
    test_max_last();
    test_back_to_back();
    test_mid_reset();
    test_idle_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
